log_hdr_rd_arb: RTL

- Shares the single log header memory read port (request and response channels) between NUM_REQ read clients.
- Example clients: the prepare engine's log-clean controller, a commit engine and a state-transfer/retransmit engine.
- Round-robin request arbitration; an in-flight tag FIFO returns each response, in order, to the client that issued the request.
- Sits between the clients and the log header memory; completely transparent to the memory.

---
 rtl/beehive_vr_pkg.sv | 13 +
 rtl/log_hdr_rd_arb_pkg.sv | 9 +
 rtl/log_hdr_rd_arb_if.sv | 39 +++
 rtl/log_hdr_rd_tag_fifo.sv | 41 ++++
 rtl/log_hdr_rd_arb.sv | 85 ++++++++
 5 files changed

// File: rtl/beehive_vr_pkg.sv
// beehive_vr_pkg: shared log header entry type and log header memory geometry.
// Contents: LOG_HDR_DEPTH_W (header memory address width), LOG_HDR_RD_ARB_MAX_INFLIGHT
// (default read-arbiter in-flight depth) and the log_entry_hdr record.
package beehive_vr_pkg;
   localparam int LOG_HDR_DEPTH_W = 8;
   localparam int LOG_HDR_RD_ARB_MAX_INFLIGHT = 4;
   typedef struct packed {
      logic [31:0] view;
      logic [31:0] op_num;
      logic [15:0] body_len;
      logic [7:0]  flags;
   } log_entry_hdr;
endpackage

// File: rtl/log_hdr_rd_arb_pkg.sv
// log_hdr_rd_arb_pkg: helpers for the log header read arbiter.
// Contents: LOG_HDR_RD_ARB_NUM_REQ default client count and rr_next(), the
// round-robin successor of a client id modulo the client count.
package log_hdr_rd_arb_pkg;
   localparam int LOG_HDR_RD_ARB_NUM_REQ = 2;
   function automatic int rr_next(input int id, input int n);
      return (id + 1 == n) ? 0 : id + 1;
   endfunction
endpackage

// File: rtl/log_hdr_rd_arb_if.sv
// log_hdr_rd_arb_if: client and memory read channels around the log header read arbiter.
// Signals: cli_arb_rd_req_val/addr, arb_cli_rd_req_rdy (client request channel),
// arb_cli_rd_resp_val/data, cli_arb_rd_resp_rdy (client response channel),
// arb_log_hdr_mem_rd_req_val/addr, log_hdr_mem_arb_rd_req_rdy (memory request channel),
// log_hdr_mem_arb_rd_resp_val/data, arb_log_hdr_mem_rd_resp_rdy (memory response channel),
// arb_err_unexp_resp (sticky error). Modport slave is the arbiter; master is its surroundings.
interface log_hdr_rd_arb_if
   import beehive_vr_pkg::*;
#(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]                 cli_arb_rd_req_val;
   logic [NUM_REQ*LOG_HDR_DEPTH_W-1:0] cli_arb_rd_req_addr;
   logic [NUM_REQ-1:0]                 arb_cli_rd_req_rdy;
   logic [NUM_REQ-1:0]                 arb_cli_rd_resp_val;
   log_entry_hdr                       arb_cli_rd_resp_data;
   logic [NUM_REQ-1:0]                 cli_arb_rd_resp_rdy;
   logic                               arb_log_hdr_mem_rd_req_val;
   logic [LOG_HDR_DEPTH_W-1:0]         arb_log_hdr_mem_rd_req_addr;
   logic                               log_hdr_mem_arb_rd_req_rdy;
   logic                               log_hdr_mem_arb_rd_resp_val;
   log_entry_hdr                       log_hdr_mem_arb_rd_resp_data;
   logic                               arb_log_hdr_mem_rd_resp_rdy;
   logic                               arb_err_unexp_resp;
   modport master (
      output cli_arb_rd_req_val, cli_arb_rd_req_addr, cli_arb_rd_resp_rdy,
             log_hdr_mem_arb_rd_req_rdy, log_hdr_mem_arb_rd_resp_val, log_hdr_mem_arb_rd_resp_data,
      input  arb_cli_rd_req_rdy, arb_cli_rd_resp_val, arb_cli_rd_resp_data,
             arb_log_hdr_mem_rd_req_val, arb_log_hdr_mem_rd_req_addr, arb_log_hdr_mem_rd_resp_rdy,
             arb_err_unexp_resp
   );
   modport slave (
      input  cli_arb_rd_req_val, cli_arb_rd_req_addr, cli_arb_rd_resp_rdy,
             log_hdr_mem_arb_rd_req_rdy, log_hdr_mem_arb_rd_resp_val, log_hdr_mem_arb_rd_resp_data,
      output arb_cli_rd_req_rdy, arb_cli_rd_resp_val, arb_cli_rd_resp_data,
             arb_log_hdr_mem_rd_req_val, arb_log_hdr_mem_rd_req_addr, arb_log_hdr_mem_rd_resp_rdy,
             arb_err_unexp_resp
   );
endinterface

// File: rtl/log_hdr_rd_tag_fifo.sv
// log_hdr_rd_tag_fifo: W-wide, DEPTH-deep FIFO of requester ids for in-flight reads.
// Ports: clk, rst (sync active-low), push/push_data, pop, head (oldest entry),
// full, empty, count (occupancy). Push and pop may occur in the same cycle.
// DEPTH must be a power of two so the pointers wrap by overflow.
module log_hdr_rd_tag_fifo #(
   parameter int W     = 1,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [W-1:0]     push_data,
   input  logic             pop,
   output logic [W-1:0]     head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   localparam int PTR_W = $clog2(DEPTH);
   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic             do_push, do_pop;
   assign full    = count == CNT_W'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= push_data;
   always_ff @(posedge clk)
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(do_push);
         rd_ptr <= rd_ptr + PTR_W'(do_pop);
         count  <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
endmodule

// File: rtl/log_hdr_rd_arb.sv
// log_hdr_rd_arb: shares the log header memory read port between NUM_REQ clients.
// Ports: clk, rst (sync active-low), bus (log_hdr_rd_arb_if.slave: client request/response
// channels, memory request/response channels, sticky arb_err_unexp_resp).
// Round-robin request arbitration; a tag FIFO routes in-order responses back to their issuer.
// Optional LOG_HDR_RD_ARB_STATS_EN adds arb_stats_grants (per-client saturating accepted-request
// counters, 32 bits each) and arb_stats_full_cycles (cycles stalled on a full tag FIFO with a request pending).
module log_hdr_rd_arb
   import beehive_vr_pkg::*;
   import log_hdr_rd_arb_pkg::*;
#(
   parameter int NUM_REQ      = LOG_HDR_RD_ARB_NUM_REQ,
   parameter int NUM_REQ_W    = $clog2(NUM_REQ),
   parameter int MAX_INFLIGHT = LOG_HDR_RD_ARB_MAX_INFLIGHT,
   parameter int INFLIGHT_W   = $clog2(MAX_INFLIGHT) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   log_hdr_rd_arb_if.slave        bus
`ifdef LOG_HDR_RD_ARB_STATS_EN
   ,
   output logic [NUM_REQ*32-1:0]  arb_stats_grants,
   output logic [31:0]            arb_stats_full_cycles
`endif
);
   logic [NUM_REQ_W-1:0]  rr_ptr, win, head;
   logic [INFLIGHT_W-1:0] count;
   logic [NUM_REQ-1:0]    elig;
   logic                  blocked, any, push, pop, fifo_full, empty, err_q;
   // Full blocks grants regardless of a same-cycle pop, so resp_rdy never reaches req_rdy.
   assign blocked = count == INFLIGHT_W'(MAX_INFLIGHT);
   assign elig    = blocked ? '0 : bus.cli_arb_rd_req_val;
   assign any     = |elig;
   // Scanning downward lets the lowest rotated offset from rr_ptr overwrite the rest.
   always_comb begin
      win = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (elig[(int'(rr_ptr) + k) % NUM_REQ]) win = NUM_REQ_W'((int'(rr_ptr) + k) % NUM_REQ);
   end
   assign push = any & bus.log_hdr_mem_arb_rd_req_rdy;
   assign pop  = ~empty & bus.log_hdr_mem_arb_rd_resp_val & bus.cli_arb_rd_resp_rdy[head];
   assign bus.arb_log_hdr_mem_rd_req_val  = any;
   assign bus.arb_log_hdr_mem_rd_req_addr = bus.cli_arb_rd_req_addr[int'(win)*LOG_HDR_DEPTH_W +: LOG_HDR_DEPTH_W];
   assign bus.arb_cli_rd_req_rdy          = push ? NUM_REQ'(1) << win : '0;
   assign bus.arb_cli_rd_resp_val         = (!empty && bus.log_hdr_mem_arb_rd_resp_val) ? NUM_REQ'(1) << head : '0;
   assign bus.arb_cli_rd_resp_data        = bus.log_hdr_mem_arb_rd_resp_data;
   // With nothing in flight a stray beat is accepted and dropped instead of stalling the memory.
   assign bus.arb_log_hdr_mem_rd_resp_rdy = empty ? bus.log_hdr_mem_arb_rd_resp_val : bus.cli_arb_rd_resp_rdy[head];
   assign bus.arb_err_unexp_resp          = err_q;
   log_hdr_rd_tag_fifo #(
      .W     (NUM_REQ_W),
      .DEPTH (MAX_INFLIGHT),
      .CNT_W (INFLIGHT_W)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (win),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (empty),
      .count     (count)
   );
   always_ff @(posedge clk)
      if (!rst) begin
         rr_ptr <= '0;
         err_q  <= 1'b0;
      end else begin
         if (push) rr_ptr <= NUM_REQ_W'(rr_next(int'(win), NUM_REQ));
         if (empty && bus.log_hdr_mem_arb_rd_resp_val) err_q <= 1'b1;
      end
   no_push_when_full: assert property (@(posedge clk) disable iff (!rst) !(fifo_full && push));
`ifdef LOG_HDR_RD_ARB_STATS_EN
   always_ff @(posedge clk)
      if (!rst) begin
         arb_stats_grants      <= '0;
         arb_stats_full_cycles <= '0;
      end else begin
         if (push && arb_stats_grants[int'(win)*32 +: 32] != '1)
            arb_stats_grants[int'(win)*32 +: 32] <= arb_stats_grants[int'(win)*32 +: 32] + 32'd1;
         if (blocked && |bus.cli_arb_rd_req_val && arb_stats_full_cycles != '1)
            arb_stats_full_cycles <= arb_stats_full_cycles + 32'd1;
      end
`endif
endmodule
